// File: rtl/mem_stage.sv
// Memory stage: request decode, store-lane alignment, single-outstanding data-bus master,
// load extraction/extension, fault detection and the MEM/WB pipeline register.
module mem_stage (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        mem_stall_i,
   input  logic        mem_flush_i,
   input  logic [31:0] mem_pc_i,
   input  logic [31:0] mem_instruction_i,
   input  logic [31:0] mem_result_i,
   input  logic [31:0] mem_store_data_i,
   input  logic [4:0]  mem_waddr_i,
   input  logic        mem_we_i,
   input  logic [5:0]  mem_mem_flags_i,
   input  logic        mem_mem_ex_sel_i,
   input  logic [4:0]  mem_exc_i,
   input  logic [31:0] mem_csr_data_i,
   input  logic [2:0]  mem_csr_op_i,
   input  logic [11:0] mem_csr_addr_i,
   output logic [31:0] mem_fwd_dat_o,
   output logic        mem_stall_req_o,
   output logic [31:0] dbus_addr_o,
   output logic [31:0] dbus_dat_o,
   output logic [3:0]  dbus_sel_o,
   output logic        dbus_we_o,
   output logic        dbus_cyc_o,
   output logic        dbus_stb_o,
   input  logic [31:0] dbus_dat_i,
   input  logic        dbus_ack_i,
   input  logic        dbus_err_i,
   output logic [31:0] wb_pc_o,
   output logic [31:0] wb_instruction_o,
   output logic [31:0] wb_wdata_o,
   output logic [4:0]  wb_waddr_o,
   output logic        wb_we_o,
   output logic [4:0]  wb_exc_o,
   output logic [3:0]  wb_exc_mem_o,
   output logic [31:0] wb_fault_addr_o,
   output logic [31:0] wb_csr_data_o,
   output logic [2:0]  wb_csr_op_o,
   output logic [11:0] wb_csr_addr_o
);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_BUS  = 1'b1;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic [31:0] wdata;
      logic [4:0]  waddr;
      logic        we;
      logic [4:0]  exc;
      logic [3:0]  exc_mem;
      logic [31:0] fault_addr;
      logic [31:0] csr_data;
      logic [2:0]  csr_op;
      logic [11:0] csr_addr;
   } wb_t;

   logic        f_read, f_write, f_byte, f_half, f_word, f_uns;
   logic        req, misaligned, go, bus_done;
   logic [31:0] st_dat;
   logic [3:0]  st_sel;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [31:0] load_data;

   logic [0:0]  state_q, state_d;
   logic        cyc_q, cyc_d;
   logic        we_q, we_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] dat_q, dat_d;
   logic [3:0]  sel_q, sel_d;
   logic [1:0]  lane_q, lane_d;
   logic        byte_q, byte_d;
   logic        half_q, half_d;
   logic        uns_q, uns_d;
   logic        flushed_q, flushed_d;
   wb_t         wb_q, wb_d;

   assign f_read  = mem_mem_flags_i[0];
   assign f_write = mem_mem_flags_i[1];
   assign f_byte  = mem_mem_flags_i[2];
   assign f_half  = mem_mem_flags_i[3];
   assign f_word  = mem_mem_flags_i[4];
   assign f_uns   = mem_mem_flags_i[5];

   assign req        = f_read | f_write;
   assign misaligned = (f_half & mem_result_i[0]) | (f_word & (mem_result_i[1:0] != 2'b00));
   assign go         = req & ~misaligned & ~(|mem_exc_i) & ~mem_flush_i;
   assign bus_done   = (state_q == S_BUS) & (dbus_ack_i | dbus_err_i);

   assign mem_stall_req_o = ((state_q == S_IDLE) & go) |
                            ((state_q == S_BUS) & ~dbus_ack_i & ~dbus_err_i);
   assign mem_fwd_dat_o   = mem_result_i;

   // Loads always fetch the full word; lanes are picked out on the way back.
   always_comb begin
      st_dat = mem_store_data_i;
      st_sel = 4'b1111;
      if (f_byte) begin
         st_dat = {4{mem_store_data_i[7:0]}};
         st_sel = 4'b0001 << mem_result_i[1:0];
      end else if (f_half) begin
         st_dat = {2{mem_store_data_i[15:0]}};
         st_sel = 4'b0011 << mem_result_i[1:0];
      end
      if (!f_write) st_sel = 4'b1111;
   end

   always_comb begin
      ld_byte = dbus_dat_i[7:0];
      case (lane_q)
         2'd1:    ld_byte = dbus_dat_i[15:8];
         2'd2:    ld_byte = dbus_dat_i[23:16];
         2'd3:    ld_byte = dbus_dat_i[31:24];
         default: ld_byte = dbus_dat_i[7:0];
      endcase
      ld_half = lane_q[1] ? dbus_dat_i[31:16] : dbus_dat_i[15:0];
      if (byte_q)      load_data = {{24{~uns_q & ld_byte[7]}}, ld_byte};
      else if (half_q) load_data = {{16{~uns_q & ld_half[15]}}, ld_half};
      else             load_data = dbus_dat_i;
   end

   always_comb begin
      state_d   = state_q;
      cyc_d     = cyc_q;
      we_d      = we_q;
      addr_d    = addr_q;
      dat_d     = dat_q;
      sel_d     = sel_q;
      lane_d    = lane_q;
      byte_d    = byte_q;
      half_d    = half_q;
      uns_d     = uns_q;
      flushed_d = flushed_q;
      case (state_q)
         S_IDLE: begin
            if (go) begin
               state_d   = S_BUS;
               cyc_d     = 1'b1;
               we_d      = f_write;
               addr_d    = {mem_result_i[31:2], 2'b00};
               dat_d     = st_dat;
               sel_d     = st_sel;
               lane_d    = mem_result_i[1:0];
               byte_d    = f_byte;
               half_d    = f_half;
               uns_d     = f_uns;
               flushed_d = 1'b0;
            end
         end
         default: begin
            if (dbus_ack_i || dbus_err_i) begin
               state_d   = S_IDLE;
               cyc_d     = 1'b0;
               we_d      = 1'b0;
               flushed_d = 1'b0;
            end else begin
               flushed_d = flushed_q | mem_flush_i;
            end
         end
      endcase
   end

   // A flush seen while the bus is busy turns the eventual completion into a bubble.
   always_comb begin
      wb_d = wb_q;
      if (mem_flush_i) begin
         wb_d = '0;
      end else if (mem_stall_i) begin
         wb_d = wb_q;
      end else if (mem_stall_req_o || (bus_done && flushed_q)) begin
         wb_d = '0;
      end else begin
         wb_d.pc         = mem_pc_i;
         wb_d.instr      = mem_instruction_i;
         wb_d.wdata      = mem_mem_ex_sel_i ? load_data : mem_result_i;
         wb_d.waddr      = mem_waddr_i;
         wb_d.exc        = mem_exc_i;
         wb_d.exc_mem    = {bus_done & dbus_err_i & we_q,
                            bus_done & dbus_err_i & ~we_q,
                            misaligned & f_write,
                            misaligned & f_read};
         wb_d.we         = mem_we_i & ~(|mem_exc_i) & ~(|wb_d.exc_mem);
         wb_d.fault_addr = mem_result_i;
         wb_d.csr_data   = mem_csr_data_i;
         wb_d.csr_op     = mem_csr_op_i;
         wb_d.csr_addr   = mem_csr_addr_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= S_IDLE;
         cyc_q     <= 1'b0;
         we_q      <= 1'b0;
         addr_q    <= '0;
         dat_q     <= '0;
         sel_q     <= '0;
         lane_q    <= '0;
         byte_q    <= 1'b0;
         half_q    <= 1'b0;
         uns_q     <= 1'b0;
         flushed_q <= 1'b0;
         wb_q      <= '0;
      end else begin
         state_q   <= state_d;
         cyc_q     <= cyc_d;
         we_q      <= we_d;
         addr_q    <= addr_d;
         dat_q     <= dat_d;
         sel_q     <= sel_d;
         lane_q    <= lane_d;
         byte_q    <= byte_d;
         half_q    <= half_d;
         uns_q     <= uns_d;
         flushed_q <= flushed_d;
         wb_q      <= wb_d;
      end
   end

   assign dbus_addr_o = addr_q;
   assign dbus_dat_o  = dat_q;
   assign dbus_sel_o  = sel_q;
   assign dbus_we_o   = we_q;
   assign dbus_cyc_o  = cyc_q;
   assign dbus_stb_o  = cyc_q;

   assign wb_pc_o          = wb_q.pc;
   assign wb_instruction_o = wb_q.instr;
   assign wb_wdata_o       = wb_q.wdata;
   assign wb_waddr_o       = wb_q.waddr;
   assign wb_we_o          = wb_q.we;
   assign wb_exc_o         = wb_q.exc;
   assign wb_exc_mem_o     = wb_q.exc_mem;
   assign wb_fault_addr_o  = wb_q.fault_addr;
   assign wb_csr_data_o    = wb_q.csr_data;
   assign wb_csr_op_o      = wb_q.csr_op;
   assign wb_csr_addr_o    = wb_q.csr_addr;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: single-cycle vector table plus hand-built bus sequences.
module tb_mem_stage;

   logic        clk = 1'b0;
   logic        rst_i = 1'b1;
   logic        mem_stall_i = 1'b0, mem_flush_i = 1'b0;
   logic [31:0] mem_pc_i = '0, mem_instruction_i = '0, mem_result_i = '0, mem_store_data_i = '0;
   logic [4:0]  mem_waddr_i = '0;
   logic        mem_we_i = 1'b0;
   logic [5:0]  mem_mem_flags_i = '0;
   logic        mem_mem_ex_sel_i = 1'b0;
   logic [4:0]  mem_exc_i = '0;
   logic [31:0] mem_csr_data_i = '0;
   logic [2:0]  mem_csr_op_i = '0;
   logic [11:0] mem_csr_addr_i = '0;
   logic [31:0] mem_fwd_dat_o;
   logic        mem_stall_req_o;
   logic [31:0] dbus_addr_o, dbus_dat_o;
   logic [3:0]  dbus_sel_o;
   logic        dbus_we_o, dbus_cyc_o, dbus_stb_o;
   logic [31:0] dbus_dat_i = '0;
   logic        dbus_ack_i = 1'b0, dbus_err_i = 1'b0;
   logic [31:0] wb_pc_o, wb_instruction_o, wb_wdata_o, wb_fault_addr_o, wb_csr_data_o;
   logic [4:0]  wb_waddr_o, wb_exc_o;
   logic        wb_we_o;
   logic [3:0]  wb_exc_mem_o;
   logic [2:0]  wb_csr_op_o;
   logic [11:0] wb_csr_addr_o;

   int n_pass = 0;
   int n_total = 0;

   mem_stage dut (
      .clk_i(clk), .rst_i(rst_i), .mem_stall_i(mem_stall_i), .mem_flush_i(mem_flush_i),
      .mem_pc_i(mem_pc_i), .mem_instruction_i(mem_instruction_i), .mem_result_i(mem_result_i),
      .mem_store_data_i(mem_store_data_i), .mem_waddr_i(mem_waddr_i), .mem_we_i(mem_we_i),
      .mem_mem_flags_i(mem_mem_flags_i), .mem_mem_ex_sel_i(mem_mem_ex_sel_i), .mem_exc_i(mem_exc_i),
      .mem_csr_data_i(mem_csr_data_i), .mem_csr_op_i(mem_csr_op_i), .mem_csr_addr_i(mem_csr_addr_i),
      .mem_fwd_dat_o(mem_fwd_dat_o), .mem_stall_req_o(mem_stall_req_o),
      .dbus_addr_o(dbus_addr_o), .dbus_dat_o(dbus_dat_o), .dbus_sel_o(dbus_sel_o),
      .dbus_we_o(dbus_we_o), .dbus_cyc_o(dbus_cyc_o), .dbus_stb_o(dbus_stb_o),
      .dbus_dat_i(dbus_dat_i), .dbus_ack_i(dbus_ack_i), .dbus_err_i(dbus_err_i),
      .wb_pc_o(wb_pc_o), .wb_instruction_o(wb_instruction_o), .wb_wdata_o(wb_wdata_o),
      .wb_waddr_o(wb_waddr_o), .wb_we_o(wb_we_o), .wb_exc_o(wb_exc_o), .wb_exc_mem_o(wb_exc_mem_o),
      .wb_fault_addr_o(wb_fault_addr_o), .wb_csr_data_o(wb_csr_data_o), .wb_csr_op_o(wb_csr_op_o),
      .wb_csr_addr_o(wb_csr_addr_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [5:0]  flags;
      logic [31:0] res;
      logic        we;
      logic [4:0]  waddr;
      logic        ex_sel;
      logic [4:0]  exc;
      logic        flush;
      logic        exp_stall;
      logic [31:0] exp_wdata;
      logic        exp_we;
      logic [3:0]  exp_excm;
   } vec_t;

   vec_t vecs[8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_alu(input logic [31:0] res, input logic we, input logic [4:0] waddr);
      mem_mem_flags_i  = 6'b0;
      mem_result_i     = res;
      mem_we_i         = we;
      mem_waddr_i      = waddr;
      mem_mem_ex_sel_i = 1'b0;
      mem_exc_i        = 5'b0;
      mem_flush_i      = 1'b0;
      mem_stall_i      = 1'b0;
   endtask

   task automatic set_mem(input logic [5:0] flags, input logic [31:0] a, input logic [31:0] d,
                          input logic we, input logic [4:0] waddr, input logic ex_sel);
      mem_mem_flags_i  = flags;
      mem_result_i     = a;
      mem_store_data_i = d;
      mem_we_i         = we;
      mem_waddr_i      = waddr;
      mem_mem_ex_sel_i = ex_sel;
      mem_exc_i        = 5'b0;
      mem_flush_i      = 1'b0;
   endtask

   // Called #1 after an edge with a memory op on the inputs; returns #1 after the capture edge.
   task automatic do_access(input int waits, input logic err, input logic [31:0] rdat,
                            output int n_stall, output int n_cyc, output logic [31:0] s_addr,
                            output logic [31:0] s_dat, output logic [3:0] s_sel, output logic s_we);
      int  w;
      bit  done;
      w = 0; done = 0; n_stall = 0; n_cyc = 0;
      s_addr = '0; s_dat = '0; s_sel = '0; s_we = 1'b0;
      for (int c = 0; c < 20 && !done; c++) begin
         if (dbus_cyc_o) begin
            if (n_cyc == 0) begin
               s_addr = dbus_addr_o; s_dat = dbus_dat_o; s_sel = dbus_sel_o; s_we = dbus_we_o;
            end
            n_cyc++;
            if (w == waits) begin
               dbus_ack_i = ~err; dbus_err_i = err; dbus_dat_i = rdat; done = 1;
            end
            w++;
         end
         #1;
         if (mem_stall_req_o) n_stall++;
         @(posedge clk);
         #1;
         dbus_ack_i = 1'b0;
         dbus_err_i = 1'b0;
      end
      if (!done) begin
         n_total++;
         $display("FAIL access_timeout: got no completion expected ack within 20 cycles");
      end
   endtask

   int          ns, nc;
   logic [31:0] sa, sd;
   logic [3:0]  ss;
   logic        sw;

   initial begin
      vecs[0] = '{6'b000000, 32'h0000_1234, 1'b1, 5'd5, 1'b0, 5'b00000, 1'b0, 1'b0, 32'h0000_1234, 1'b1, 4'b0000};
      vecs[1] = '{6'b010001, 32'h0000_0101, 1'b1, 5'd6, 1'b0, 5'b00000, 1'b0, 1'b0, 32'h0000_0101, 1'b0, 4'b0001};
      vecs[2] = '{6'b001010, 32'h0000_0203, 1'b0, 5'd0, 1'b0, 5'b00000, 1'b0, 1'b0, 32'h0000_0203, 1'b0, 4'b0010};
      vecs[3] = '{6'b101001, 32'h0000_0201, 1'b1, 5'd2, 1'b0, 5'b00000, 1'b0, 1'b0, 32'h0000_0201, 1'b0, 4'b0001};
      vecs[4] = '{6'b010001, 32'h0000_0100, 1'b1, 5'd4, 1'b0, 5'b00100, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 4'b0000};
      vecs[5] = '{6'b000000, 32'h0000_0077, 1'b1, 5'd9, 1'b0, 5'b00001, 1'b0, 1'b0, 32'h0000_0077, 1'b0, 4'b0000};
      vecs[6] = '{6'b000000, 32'h0000_0099, 1'b1, 5'd3, 1'b0, 5'b00000, 1'b1, 1'b0, 32'h0000_0000, 1'b0, 4'b0000};
      vecs[7] = '{6'b010001, 32'h0000_0200, 1'b1, 5'd3, 1'b1, 5'b00000, 1'b1, 1'b0, 32'h0000_0000, 1'b0, 4'b0000};

      tick(); tick();
      rst_i = 1'b0;
      #1;
      chk("reset_cyc", {31'b0, dbus_cyc_o}, 32'd0);
      chk("reset_wb_we", {31'b0, wb_we_o}, 32'd0);
      chk("reset_addr", dbus_addr_o, 32'd0);
      chk("reset_stall", {31'b0, mem_stall_req_o}, 32'd0);
      tick();

      for (int i = 0; i < 8; i++) begin
         mem_mem_flags_i  = vecs[i].flags;
         mem_result_i     = vecs[i].res;
         mem_we_i         = vecs[i].we;
         mem_waddr_i      = vecs[i].waddr;
         mem_mem_ex_sel_i = vecs[i].ex_sel;
         mem_exc_i        = vecs[i].exc;
         mem_flush_i      = vecs[i].flush;
         mem_pc_i         = 32'h1000 + 32'(i * 4);
         #1;
         chk($sformatf("v%0d_stall", i), {31'b0, mem_stall_req_o}, {31'b0, vecs[i].exp_stall});
         chk($sformatf("v%0d_fwd", i), mem_fwd_dat_o, vecs[i].res);
         tick();
         chk($sformatf("v%0d_wdata", i), wb_wdata_o, vecs[i].exp_wdata);
         chk($sformatf("v%0d_we", i), {31'b0, wb_we_o}, {31'b0, vecs[i].exp_we});
         chk($sformatf("v%0d_excm", i), {28'b0, wb_exc_mem_o}, {28'b0, vecs[i].exp_excm});
         chk($sformatf("v%0d_exc", i), {27'b0, wb_exc_o}, vecs[i].flush ? 32'd0 : {27'b0, vecs[i].exc});
         chk($sformatf("v%0d_waddr", i), {27'b0, wb_waddr_o}, vecs[i].flush ? 32'd0 : {27'b0, vecs[i].waddr});
         chk($sformatf("v%0d_pc", i), wb_pc_o, vecs[i].flush ? 32'd0 : 32'h1000 + 32'(i * 4));
         chk($sformatf("v%0d_cyc", i), {31'b0, dbus_cyc_o}, 32'd0);
      end
      chk("misaligned_fault_addr", wb_fault_addr_o, 32'd0);
      set_alu(32'h0, 1'b0, 5'd0);
      mem_pc_i = 32'h0;

      // signed byte load, immediate ack
      set_mem(6'b000101, 32'h0000_0103, 32'h0, 1'b1, 5'd3, 1'b1);
      do_access(0, 1'b0, 32'h80FF_FF00, ns, nc, sa, sd, ss, sw);
      chk("lb_wdata", wb_wdata_o, 32'hFFFF_FF80);
      chk("lb_we", {31'b0, wb_we_o}, 32'd1);
      chk("lb_waddr", {27'b0, wb_waddr_o}, 32'd3);
      chk("lb_stall_cycles", ns, 1);
      chk("lb_cyc_cycles", nc, 1);
      chk("lb_addr", sa, 32'h0000_0100);
      chk("lb_sel", {28'b0, ss}, 32'hF);
      chk("lb_bus_we", {31'b0, sw}, 32'd0);
      chk("lb_cyc_after", {31'b0, dbus_cyc_o}, 32'd0);
      set_alu(32'h0, 1'b0, 5'd0);
      tick();

      // unsigned byte load
      set_mem(6'b100101, 32'h0000_0103, 32'h0, 1'b1, 5'd3, 1'b1);
      do_access(0, 1'b0, 32'h80FF_FF00, ns, nc, sa, sd, ss, sw);
      chk("lbu_wdata", wb_wdata_o, 32'h0000_0080);
      set_alu(32'h0, 1'b0, 5'd0);
      tick();

      // signed half load from upper lane
      set_mem(6'b001001, 32'h0000_0302, 32'h0, 1'b1, 5'd8, 1'b1);
      do_access(1, 1'b0, 32'h9ABC_5678, ns, nc, sa, sd, ss, sw);
      chk("lh_wdata", wb_wdata_o, 32'hFFFF_9ABC);
      chk("lh_stall_cycles", ns, 2);
      set_alu(32'h0, 1'b0, 5'd0);
      tick();

      // half store, three wait states
      set_mem(6'b001010, 32'h0000_0202, 32'hABCD_1234, 1'b0, 5'd0, 1'b0);
      do_access(3, 1'b0, 32'h0, ns, nc, sa, sd, ss, sw);
      chk("sh_dat", sd, 32'h1234_1234);
      chk("sh_sel", {28'b0, ss}, 32'hC);
      chk("sh_bus_we", {31'b0, sw}, 32'd1);
      chk("sh_addr", sa, 32'h0000_0200);
      chk("sh_stall_cycles", ns, 4);
      chk("sh_cyc_cycles", nc, 4);
      chk("sh_wb_we", {31'b0, wb_we_o}, 32'd0);
      chk("sh_excm", {28'b0, wb_exc_mem_o}, 32'd0);
      set_alu(32'h0, 1'b0, 5'd0);
      tick();

      // bus error on word write
      set_mem(6'b010010, 32'h0000_0400, 32'h5555_AAAA, 1'b0, 5'd0, 1'b0);
      do_access(0, 1'b1, 32'h0, ns, nc, sa, sd, ss, sw);
      chk("sw_err_excm", {28'b0, wb_exc_mem_o}, 32'h8);
      chk("sw_err_fault_addr", wb_fault_addr_o, 32'h0000_0400);
      chk("sw_err_cyc_after", {31'b0, dbus_cyc_o}, 32'd0);
      chk("sw_err_dat", sd, 32'h5555_AAAA);
      set_alu(32'h0, 1'b0, 5'd0);
      tick();

      // bus error on word read
      set_mem(6'b010001, 32'h0000_0500, 32'h0, 1'b1, 5'd4, 1'b1);
      do_access(0, 1'b1, 32'h0, ns, nc, sa, sd, ss, sw);
      chk("lw_err_excm", {28'b0, wb_exc_mem_o}, 32'h4);
      chk("lw_err_we", {31'b0, wb_we_o}, 32'd0);
      set_alu(32'h0, 1'b0, 5'd0);
      tick();

      // flush while the bus is busy: transaction completes, result dropped
      set_mem(6'b010001, 32'h0000_0100, 32'h0, 1'b1, 5'd7, 1'b1);
      tick();
      chk("fl_cyc", {31'b0, dbus_cyc_o}, 32'd1);
      mem_flush_i = 1'b1;
      #1;
      chk("fl_stall_held", {31'b0, mem_stall_req_o}, 32'd1);
      tick();
      mem_flush_i = 1'b0;
      chk("fl_cyc_still", {31'b0, dbus_cyc_o}, 32'd1);
      dbus_ack_i = 1'b1;
      dbus_dat_i = 32'h1234_5678;
      #1;
      chk("fl_stall_drop", {31'b0, mem_stall_req_o}, 32'd0);
      tick();
      dbus_ack_i = 1'b0;
      chk("fl_wb_we", {31'b0, wb_we_o}, 32'd0);
      chk("fl_wb_wdata", wb_wdata_o, 32'd0);
      chk("fl_cyc_after", {31'b0, dbus_cyc_o}, 32'd0);
      set_alu(32'h0, 1'b0, 5'd0);
      tick();

      // external stall holds, flush beats stall
      set_alu(32'h55, 1'b1, 5'd1);
      mem_csr_addr_i = 12'h305;
      tick();
      chk("hold_setup", wb_wdata_o, 32'h55);
      chk("csr_addr", {20'b0, wb_csr_addr_o}, 32'h305);
      mem_stall_i = 1'b1;
      mem_result_i = 32'h66;
      mem_waddr_i = 5'd2;
      tick();
      chk("hold_wdata", wb_wdata_o, 32'h55);
      chk("hold_waddr", {27'b0, wb_waddr_o}, 32'd1);
      mem_flush_i = 1'b1;
      tick();
      chk("flush_over_stall_wdata", wb_wdata_o, 32'd0);
      chk("flush_over_stall_we", {31'b0, wb_we_o}, 32'd0);
      mem_csr_addr_i = 12'h0;
      set_alu(32'h0, 1'b0, 5'd0);
      tick();

      // reset in the middle of a bus access, then a late ack
      mem_pc_i = 32'h0000_0ABC;
      set_mem(6'b010001, 32'h0000_0100, 32'h0, 1'b1, 5'd7, 1'b1);
      tick();
      chk("rst_cyc_before", {31'b0, dbus_cyc_o}, 32'd1);
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      chk("rst_cyc_after", {31'b0, dbus_cyc_o}, 32'd0);
      chk("rst_wb_pc", wb_pc_o, 32'd0);
      chk("rst_wb_we", {31'b0, wb_we_o}, 32'd0);
      set_alu(32'h42, 1'b1, 5'd2);
      dbus_ack_i = 1'b1;
      dbus_dat_i = 32'hDEAD_BEEF;
      #1;
      chk("late_ack_stall", {31'b0, mem_stall_req_o}, 32'd0);
      tick();
      dbus_ack_i = 1'b0;
      chk("late_ack_wdata", wb_wdata_o, 32'h42);
      chk("late_ack_cyc", {31'b0, dbus_cyc_o}, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
Memory stage of the 5-stage pipeline, directly downstream of the EX/MEM register. It decodes the memory flags, aligns store data, and runs a registered Wishbone-style data-bus master with a two-state FSM. It extracts and extends load data, detects misalignment and bus errors, requests pipeline stalls while an access is outstanding, and contains the MEM/WB pipeline register.

Parameters:
None. All datapaths are 32-bit, with a 4-bit byte select.

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
mem_stall_i  in  1  hazard-unit stall; MEM/WB holds its contents
mem_flush_i  in  1  flush; MEM/WB loads a bubble
mem_pc_i  in  32  instruction PC
mem_instruction_i  in  32  instruction word
mem_result_i  in  32  ALU result, which is also the effective address
mem_store_data_i  in  32  raw store operand
mem_waddr_i  in  5  destination register
mem_we_i  in  1  register write enable
mem_mem_flags_i  in  6  {unsigned, word, half, byte, write, read}
mem_mem_ex_sel_i  in  1  1 = writeback takes load data, 0 = ALU result
mem_exc_i  in  5  {exc_addr_if, syscall, break, bad_branch, bad_jump}
mem_csr_data_i  in  32  CSR write data
mem_csr_op_i  in  3  CSR op
mem_csr_addr_i  in  12  CSR address
mem_fwd_dat_o  out  32  forwarding data, equal to mem_result_i
mem_stall_req_o  out  1  stall request to the hazard unit
dbus_addr_o  out  32  word-aligned address
dbus_dat_o  out  32  lane-aligned store data
dbus_sel_o  out  4  byte lanes
dbus_we_o  out  1  write strobe
dbus_cyc_o  out  1  cycle
dbus_stb_o  out  1  strobe
dbus_dat_i  in  32  read data
dbus_ack_i  in  1  acknowledge
dbus_err_i  in  1  bus error
wb_pc_o  out  32  registered PC
wb_instruction_o  out  32  registered instruction
wb_wdata_o  out  32  registered writeback data
wb_waddr_o  out  5  registered destination register
wb_we_o  out  1  registered write enable
wb_exc_o  out  5  registered copy of mem_exc_i
wb_exc_mem_o  out  4  {store_fault, load_fault, misaligned_store, misaligned_load}
wb_fault_addr_o  out  32  registered mem_result_i
wb_csr_data_o  out  32  registered CSR data
wb_csr_op_o  out  3  registered CSR op
wb_csr_addr_o  out  12  registered CSR address

Behaviour:
- Request decode
  - req = read|write.
  - Size is one-hot (byte/half/word). The block's behaviour is undefined if more than one size bit is set.
  - misaligned = (half & a[0]) | (word & a[1:0]!=0), where a = mem_result_i.
  - go = req & ~misaligned & ~(|mem_exc_i) & ~mem_flush_i.
- Store alignment
  - byte: data {4{d[7:0]}}, sel = 0001<<a[1:0].
  - half: data {2{d[15:0]}}, sel = 0011<<a[1:0].
  - word: data d, sel = 1111.
- Load extraction
  - Byte or half is selected by a[1:0] from dbus_dat_i.
  - It is sign-extended unless the unsigned flag is set.
- FSM states: IDLE and BUS.
  - Reset: state=IDLE; cyc, stb, we=0; addr, dat, sel=0.
  - IDLE & go: register addr={a[31:2],2'b00}, dat, sel, we=write, cyc=stb=1; next state BUS.
  - BUS & (ack|err): next cycle cyc=stb=we=0; next state IDLE.
  - BUS otherwise: all bus outputs hold.
- Stall request
  - mem_stall_req_o = (IDLE & go) | (BUS & ~ack & ~err). This is combinational.
  - Minimum access latency is 2 cycles: one request cycle plus one ack cycle.
  - In the ack/err cycle the stall drops and MEM/WB captures the result that same edge.
- Flush
  - Flush in IDLE suppresses the access.
  - Flush in BUS does not abort the access: the transaction runs to ack/err and its result is discarded (MEM/WB loads a bubble).
  - mem_stall_req_o stays asserted until ack/err.
- MEM/WB register priority: rst_i > mem_flush_i > mem_stall_i > mem_stall_req_o > capture.
  - Reset or flush: all wb_* outputs = 0 (a bubble: wb_we_o=0, no exceptions).
  - mem_stall_i: hold all wb_* outputs.
  - Own stall request: bubble into WB.
  - Capture: wb_wdata_o = ex_sel ? load_data : mem_result_i; wb_we_o = mem_we_i & ~any_exception.
  - On misalignment: set the corresponding misaligned bit; no bus access occurs.
  - On err during a read: set load_fault. On err during a write: set store_fault.
  - wb_fault_addr_o = a.
- Reset mid-access: rst_i forces IDLE and drops cyc/stb in the next cycle. Any late ack from the slave is ignored.
- Non-memory instructions: no stall; the ALU result passes through in one cycle.

Test Plan:
- ALU instruction: mem_flags=0, result=0x1234, we=1, waddr=5 -> next edge wb_wdata_o=0x1234, wb_waddr_o=5, wb_we_o=1, mem_stall_req_o never asserted.
- Signed load byte: a=0x103, slave acks first bus cycle with 0x80FF_FF00 -> cyc high 1 cycle, sel=1111, dbus_addr_o=0x100, stall for 1 cycle, wb_wdata_o=0xFFFF_FF80. Repeat with unsigned set -> 0x0000_0080.
- Store half: a=0x202, d=0xABCD_1234, slave acks after 3 wait cycles -> dat=0x1234_1234, sel=1100, we=1, stall held 4 cycles, then wb_we_o=0 for a store with rd=0.
- Misaligned word load: a=0x101 -> no cyc, no stall, wb_exc_mem_o=0001, wb_fault_addr_o=0x101, wb_we_o=0.
- Bus error on write at 0x400 -> cyc drops after err, wb_exc_mem_o=1000.
- Flush during BUS, followed by ack -> wb_we_o=0. Flush with mem_stall_i asserted -> flush wins. mem_stall_i alone -> wb_* held.
- rst_i asserted mid-BUS -> state IDLE and cyc=0 next cycle; all wb_* outputs = 0.
